// File: rtl/full_st1_pass_sequencer.sv
// Stage-1 layer pass sequencer: walks a layer through its forward passes and
// optional error-update passes, then flushes the pipeline and signals done.
module full_st1_pass_sequencer #(
    parameter int DEPTH_W      = 3,
    parameter int LENGTH_W     = 4,
    parameter int DRAIN_CYCLES = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [DEPTH_W-1:0]  cfg_depth,
    input  logic [LENGTH_W-1:0] cfg_length,
    input  logic                cfg_error_en,
    input  logic                flush,
    input  logic                state_finish,
    input  logic                error_vld,
    output logic                error_rdy,
    output logic [DEPTH_W-1:0]  load_depth,
    output logic [LENGTH_W-1:0] load_length,
    output logic                error_update_mode,
    output logic                error_update_latch,
    output logic                error_update_first,
    output logic                error_finish_tap,
    output logic                error_tap_update_out,
    output logic                busy,
    output logic                done
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        ERR_WAIT,
        ERR_UPDATE,
        DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic [DEPTH_W-1:0]    pass_cnt_q, pass_cnt_d;
    logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic [LENGTH_W-1:0]   length_q, length_d;
    logic                  err_en_q, err_en_d;
    logic                  mode_q, mode_d;
    logic                  latch_q, latch_d;
    logic                  first_q, first_d;
    logic                  tap_q, tap_d;
    logic                  tap_upd_q, tap_upd_d;
    logic                  done_q, done_d;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        pass_cnt_d  = pass_cnt_q;
        drain_cnt_d = drain_cnt_q;
        depth_d     = depth_q;
        length_d    = length_q;
        err_en_d    = err_en_q;
        mode_d      = 1'b0;
        tap_d       = 1'b0;
        tap_upd_d   = 1'b0;
        done_d      = 1'b0;

        if (flush) begin
            state_d     = IDLE;
            pass_cnt_d  = '0;
            drain_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        depth_d    = cfg_depth;
                        length_d   = cfg_length;
                        err_en_d   = cfg_error_en;
                        pass_cnt_d = '0;
                        state_d    = FWD;
                    end
                end
                FWD: begin
                    if (state_finish) begin
                        // Compare before incrementing so depth = all-ones never wraps.
                        if (pass_cnt_q == depth_q) begin
                            pass_cnt_d = '0;
                            if (err_en_q) begin
                                state_d = ERR_WAIT;
                            end else begin
                                state_d     = DRAIN;
                                drain_cnt_d = DRAIN_W'(DRAIN_CYCLES - 1);
                            end
                        end else begin
                            pass_cnt_d = pass_cnt_q + 1'b1;
                        end
                    end
                end
                ERR_WAIT: begin
                    if (error_vld) begin
                        mode_d  = 1'b1;
                        state_d = ERR_UPDATE;
                    end
                end
                ERR_UPDATE: begin
                    if (state_finish) begin
                        tap_d = 1'b1;
                        if (pass_cnt_q == depth_q) begin
                            tap_upd_d   = 1'b1;
                            pass_cnt_d  = '0;
                            state_d     = DRAIN;
                            drain_cnt_d = DRAIN_W'(DRAIN_CYCLES - 1);
                        end else begin
                            pass_cnt_d = pass_cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Levels follow the next state so they line up with the registered strobes.
        latch_d = (state_d == ERR_UPDATE);
        first_d = latch_d && (pass_cnt_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pass_cnt_q  <= '0;
            drain_cnt_q <= '0;
            depth_q     <= '0;
            length_q    <= '0;
            err_en_q    <= 1'b0;
            mode_q      <= 1'b0;
            latch_q     <= 1'b0;
            first_q     <= 1'b0;
            tap_q       <= 1'b0;
            tap_upd_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_cnt_q  <= pass_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            depth_q     <= depth_d;
            length_q    <= length_d;
            err_en_q    <= err_en_d;
            mode_q      <= mode_d;
            latch_q     <= latch_d;
            first_q     <= first_d;
            tap_q       <= tap_d;
            tap_upd_q   <= tap_upd_d;
            done_q      <= done_d;
        end
    end

    assign cfg_ready            = (state_q == IDLE);
    assign error_rdy            = (state_q == ERR_WAIT);
    assign busy                 = (state_q != IDLE);
    assign load_depth           = depth_q;
    assign load_length          = length_q;
    assign error_update_mode    = mode_q;
    assign error_update_latch   = latch_q;
    assign error_update_first   = first_q;
    assign error_finish_tap     = tap_q;
    assign error_tap_update_out = tap_upd_q;
    assign done                 = done_q;

endmodule
